// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX register fields and status
// in, write enables, flush, bubble select and performance counters out.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_mem_read;
    logic                  branch_taken;
    logic                  mem_busy;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_write;
    logic                  ex_mem_write;
    logic                  haz_mux_con;
    logic                  stall_active;
    logic [CNT_W-1:0]      perf_stall_cnt;
    logic [CNT_W-1:0]      perf_flush_cnt;

    modport master (
        output id_rs, id_rt, ex_rt, ex_mem_read, branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, ex_mem_write,
               haz_mux_con, stall_active, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, ex_mem_read, branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_write, ex_mem_write,
               haz_mux_con, stall_active, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch / memory-freeze hazard controller for the 5-stage pipeline.
// Define HAZARD_PERF_EN to build the saturating stall and flush performance counters.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

    localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       hazard;
    logic       pc_write_c, if_id_write_c, if_id_flush_c;
    logic       id_ex_write_c, ex_mem_write_c, haz_mux_con_c;

    // Register zero is hard-wired, so a load targeting it never creates a dependency.
    assign hazard = bus.ex_mem_read
                 && (bus.ex_rt != {REG_ADDR_W{1'b0}})
                 && ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_write_c  = 1'b0;
        ex_mem_write_c = 1'b0;
        haz_mux_con_c  = 1'b0;
        // A busy data memory freezes everything, including the stall countdown.
        if (!reset && !bus.mem_busy) begin
            if (state_q == STALL) begin
                id_ex_write_c  = 1'b1;
                ex_mem_write_c = 1'b1;
                haz_mux_con_c  = 1'b1;
                cnt_d          = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                end
            end else if (hazard) begin
                id_ex_write_c  = 1'b1;
                ex_mem_write_c = 1'b1;
                haz_mux_con_c  = 1'b1;
                if (LOAD_STALL > 1) begin
                    state_d = STALL;
                    cnt_d   = STALL_LOAD;
                end
            end else begin
                pc_write_c     = 1'b1;
                if_id_write_c  = 1'b1;
                id_ex_write_c  = 1'b1;
                ex_mem_write_c = 1'b1;
                if_id_flush_c  = bus.branch_taken;
            end
        end
    end

    assign bus.pc_write     = pc_write_c;
    assign bus.if_id_write  = if_id_write_c;
    assign bus.if_id_flush  = if_id_flush_c;
    assign bus.id_ex_write  = id_ex_write_c;
    assign bus.ex_mem_write = ex_mem_write_c;
    assign bus.haz_mux_con  = haz_mux_con_c;
    assign bus.stall_active = (state_q == STALL) && !reset;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (haz_mux_con_c && !bus.mem_busy && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (if_id_flush_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
`else
    assign bus.perf_stall_cnt = {CNT_W{1'b0}};
    assign bus.perf_flush_cnt = {CNT_W{1'b0}};
`endif
endmodule
